// File: rtl/gamma_pkg.sv
// gamma_pkg: shared defaults, types and helpers for the gamma-cycle temporal
// encoder.
//   GAMMA_CYCLE_WIDTH_DEF : default clocks per gamma cycle (power of 2)
//   PULSE_WIDTH_DEF       : default pulse length in clocks
//   INPUT_WIDTH_DEF       : bits needed to hold one gamma phase
//   phase_t               : gamma phase type at the default width
//   pulse_hit()           : pulse window test for one lane
package gamma_pkg;

    localparam int GAMMA_CYCLE_WIDTH_DEF = 16;
    localparam int PULSE_WIDTH_DEF       = 8;
    localparam int INPUT_WIDTH_DEF       = $clog2(GAMMA_CYCLE_WIDTH_DEF);

    typedef logic [INPUT_WIDTH_DEF-1:0] phase_t;

    // True when phase lies in [start, start+pulse_width-1]. The upper bound
    // is formed wider than a phase, so a window that runs past the last
    // phase of the gamma cycle is truncated instead of wrapping back to 0.
    function automatic logic pulse_hit(input int unsigned phase,
                                       input int unsigned start,
                                       input int unsigned pulse_width);
        return (phase >= start) && (phase <= start + pulse_width - 1);
    endfunction

endpackage

// File: rtl/enc_b_t_lane.sv
// enc_b_t_lane: one lane of the binary-to-temporal encoder. It holds the
// active spike time and mask for the gamma cycle being played, and registers
// the lane's pulse output.
//   aclk, grst_n : clock, async active-low reset
//   load         : copy the pending time/mask into the active registers
//   act_vld_nxt  : active-vector flag as it will be after this edge
//   phase_nxt    : gamma phase as it will be after this edge
//   pend_data    : pending spike time for this lane
//   pend_mask    : pending lane enable
//   pulse        : registered temporal pulse output
module enc_b_t_lane
    import gamma_pkg::*;
#(
    parameter int INPUT_WIDTH = INPUT_WIDTH_DEF,
    parameter int PULSE_WIDTH = PULSE_WIDTH_DEF
) (
    input  logic                   aclk,
    input  logic                   grst_n,
    input  logic                   load,
    input  logic                   act_vld_nxt,
    input  logic [INPUT_WIDTH-1:0] phase_nxt,
    input  logic [INPUT_WIDTH-1:0] pend_data,
    input  logic                   pend_mask,
    output logic                   pulse
);

    logic [INPUT_WIDTH-1:0] act_data;
    logic [INPUT_WIDTH-1:0] act_data_nxt;
    logic                   act_mask;
    logic                   act_mask_nxt;

    always_comb begin
        act_data_nxt = load ? pend_data : act_data;
        act_mask_nxt = load ? pend_mask : act_mask;
    end

    // The pulse is evaluated on next-cycle values so the registered output
    // lines up with the phase counter instead of trailing it by one clock.
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            act_data <= '0;
            act_mask <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            act_data <= act_data_nxt;
            act_mask <= act_mask_nxt;
            pulse    <= act_vld_nxt && act_mask_nxt &&
                        pulse_hit(32'(phase_nxt), 32'(act_data_nxt),
                                  unsigned'(PULSE_WIDTH));
        end
    end

endmodule

// File: rtl/enc_b_t_n.sv
// enc_b_t_n: binary-to-temporal encoder. It accepts a vector of per-lane
// spike times through a valid/ready handshake. In the following gamma cycle
// it plays one pulse per enabled lane, starting at the phase equal to that
// lane's value.
//   aclk, grst_n : clock, async active-low reset
//   in_valid     : input vector valid
//   in_ready     : a vector can be accepted (pending buffer empty)
//   in_data      : per-lane spike time (gamma phase)
//   in_mask      : per-lane enable, 0 = no spike this gamma
//   gamma_start  : high while the gamma phase is 0
//   out_active   : high for every clock of a gamma cycle played from a vector
//   out          : registered temporal pulse outputs
module enc_b_t_n
    import gamma_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
    parameter int PULSE_WIDTH       = PULSE_WIDTH_DEF,
    parameter int NUM_INPUTS        = 16,
    parameter int INPUT_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                                  aclk,
    input  logic                                  grst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]                  in_mask,
    output logic                                  gamma_start,
    output logic                                  out_active,
    output logic [NUM_INPUTS-1:0]                  out
);

    logic [INPUT_WIDTH-1:0]                  phase;
    logic [INPUT_WIDTH-1:0]                  phase_nxt;
    logic                                    boundary;
    logic                                    load;
    logic                                    xfer;
    logic                                    pend_vld;
    logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0]  pend_data;
    logic [NUM_INPUTS-1:0]                   pend_mask;
    logic                                    act_vld;
    logic                                    act_vld_nxt;

    // The gamma length is a power of two, so the counter wraps on its own and
    // the last phase is the all-ones value.
    always_comb begin
        phase_nxt   = phase + 1'b1;
        boundary    = &phase;
        load        = boundary && pend_vld;
        xfer        = in_valid && in_ready;
        act_vld_nxt = boundary ? pend_vld : act_vld;
    end

    assign in_ready    = ~pend_vld;
    assign gamma_start = (phase == '0);
    assign out_active  = act_vld;

    // A load needs pend_vld set and a transfer needs it clear, so the two
    // never coincide. A transfer on the boundary edge itself therefore waits
    // a full gamma cycle.
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            phase     <= '0;
            pend_vld  <= 1'b0;
            pend_data <= '0;
            pend_mask <= '0;
            act_vld   <= 1'b0;
        end else begin
            phase   <= phase_nxt;
            act_vld <= act_vld_nxt;
            if (load) begin
                pend_vld <= 1'b0;
            end else if (xfer) begin
                pend_vld  <= 1'b1;
                pend_data <= in_data;
                pend_mask <= in_mask;
            end
        end
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        enc_b_t_lane #(
            .INPUT_WIDTH (INPUT_WIDTH),
            .PULSE_WIDTH (PULSE_WIDTH)
        ) u_lane (
            .aclk        (aclk),
            .grst_n      (grst_n),
            .load        (load),
            .act_vld_nxt (act_vld_nxt),
            .phase_nxt   (phase_nxt),
            .pend_data   (pend_data[i]),
            .pend_mask   (pend_mask[i]),
            .pulse       (out[i])
        );
    end

endmodule
